ring_counter_decoder: RTL and testbench
=======================================

// Module: ring_counter_decoder
//
// PURPOSE
//   Receive-side companion to the one-hot ring counter. Samples an N-bit one-hot ring
//   vector and returns the bit position as a registered binary index. Checks that the
//   vector is exactly one-hot and that each sample is the rotate-left successor of the
//   previous one. Counts completed laps. Sits downstream of any one-hot ring source as
//   a decoder and integrity monitor.
//
// PARAMETERS
//   N      4  ring width in bits (N >= 2)
//   LAP_W  8  lap counter width in bits
//   IDX_W  derived: $clog2(N); not overridable
//
// PORTS
//   clk        in   1      rising-edge clock; the only clock
//   rst        in   1      synchronous, active-high reset
//   en         in   1      sample qualifier; ring_in is evaluated only when en=1
//   ring_in    in   N      one-hot ring vector; bit k set means position k
//   idx        out  IDX_W  binary index of the last accepted one-hot sample
//   idx_valid  out  1      idx tracks a locked ring
//   onehot_err out  1      1-cycle pulse: sampled vector had zero or >1 bits set
//   seq_err    out  1      1-cycle pulse: valid one-hot, but not rotl(prev)
//   lap_pulse  out  1      1-cycle pulse: correct transition from position N-1 to 0
//   lap_cnt    out  LAP_W  number of completed laps, modulo 2^LAP_W
//
// BEHAVIOUR
//   - Reset:
//     - idx=0, idx_valid=0, onehot_err=0, seq_err=0, lap_pulse=0, lap_cnt=0.
//     - Internal prev=0; state=SYNC.
//   - Latency: all outputs are registered; the response to a sample appears 1 clk later.
//   - en=0: no state change. idx, idx_valid and lap_cnt hold. All pulses are 0 next cycle.
//   - States:
//     - SYNC: no reference vector held.
//     - TRACK: prev holds the last accepted vector.
//   - SYNC, en=1, valid one-hot:
//     - idx=position, prev=ring_in, idx_valid=1, go to TRACK.
//     - No seq check and no lap is counted.
//   - SYNC, en=1, not one-hot: onehot_err=1; stay in SYNC; idx holds; idx_valid=0.
//   - TRACK, en=1, ring_in == rotl(prev,1) (bit N-1 wraps to bit 0):
//     - idx=position, prev=ring_in.
//     - If prev position was N-1: lap_pulse=1 and lap_cnt+1. lap_cnt wraps to 0 silently.
//   - TRACK, en=1, valid one-hot but not the successor (this includes ring_in == prev):
//     - seq_err=1; resynchronise to the new vector: idx=position, prev=ring_in.
//     - Stay in TRACK. No lap is counted.
//   - TRACK, en=1, not one-hot (0 or >=2 bits set):
//     - onehot_err=1, idx_valid=0, idx holds, go to SYNC.
//     - seq_err is not asserted on this cycle.
//   - onehot_err and seq_err are never asserted on the same cycle.
//   - rst wins over en on the same edge. Reset mid-lap clears lap_cnt and forces SYNC.
//   - Position encoding: index k for bit k (LSB = position 0), matching the ring source.
//
// CONFIGURATION
//   - Macro RING_DEC_ERR_COUNT_EN.
//   - Defined:
//     - Adds output err_cnt [7:0], reset to 0.
//     - err_cnt increments on every onehot_err or seq_err pulse.
//     - err_cnt saturates at 8'hFF.
//     - err_cnt is cleared only by rst.
//   - Undefined: port err_cnt and its logic are absent. All other behaviour is identical.
//
// TESTING
//   - rst=1 for 2 clk, then release:
//     - idx=0, idx_valid=0, lap_cnt=0, all pulses 0.
//   - en=1, ring_in 0001,0010,0100,1000,0001:
//     - idx 0,1,2,3,0 with idx_valid=1 from the first sample onward.
//     - lap_pulse=1 only after the final 0001; lap_cnt=1; no errors.
//   - In TRACK at 0010, ring_in=0000:
//     - onehot_err=1, idx_valid=0, idx stays 1.
//     - Next sample 0100: idx=2, idx_valid=1, no seq_err.
//   - In TRACK at 0001, ring_in=0100: seq_err=1, idx=2. Next 1000: no error, idx=3.
//   - ring_in 0110: onehot_err=1.
//   - en=0 with random ring_in: idx, idx_valid and lap_cnt are unchanged; no pulses.
//   - LAP_W=2, run 5 clean laps: lap_cnt 1,2,3,0,1.
//   - rst asserted mid-lap: lap_cnt=0, idx_valid=0.
//   - RING_DEC_ERR_COUNT_EN defined, 300 alternating 0000/0001 samples:
//     - err_cnt saturates at 255; rst returns it to 0.

Source files
------------

// File: rtl/ring_counter_decoder.sv
// Decoder and integrity monitor for a one-hot ring: binary index, one-hot/sequence checks, lap count.
// Optional saturating error counter output err_cnt is enabled by defining RING_DEC_ERR_COUNT_EN.
module ring_counter_decoder #(
  parameter int N     = 4,
  parameter int LAP_W = 8,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N-1:0]     ring_in,
  output logic [IDX_W-1:0] idx,
  output logic             idx_valid,
  output logic             onehot_err,
  output logic             seq_err,
  output logic             lap_pulse,
`ifdef RING_DEC_ERR_COUNT_EN
  output logic [7:0]       err_cnt,
`endif
  output logic [LAP_W-1:0] lap_cnt
);

  typedef enum logic {SYNC = 1'b0, TRACK = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [N-1:0]       prev_q, prev_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               valid_q, valid_d;
  logic               oh_err_q, oh_err_d;
  logic               seq_err_q, seq_err_d;
  logic               lap_pulse_q, lap_pulse_d;
  logic [LAP_W-1:0]   lap_cnt_q, lap_cnt_d;

  logic               is_onehot_s;
  logic [N-1:0]       succ_s;
  logic [IDX_W-1:0]   pos_s;

  function automatic logic [IDX_W-1:0] onehot_pos(input logic [N-1:0] v);
    logic [IDX_W-1:0] p;
    p = {IDX_W{1'b0}};
    for (int k = 0; k < N; k++) begin
      if (v[k]) begin
        p = IDX_W'(k);
      end
    end
    return p;
  endfunction

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign is_onehot_s = (ring_in != {N{1'b0}}) &&
                       ((ring_in & (ring_in - {{(N-1){1'b0}}, 1'b1})) == {N{1'b0}});
  assign succ_s      = {prev_q[N-2:0], prev_q[N-1]};
  assign pos_s       = onehot_pos(ring_in);

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    idx_d       = idx_q;
    valid_d     = valid_q;
    oh_err_d    = 1'b0;
    seq_err_d   = 1'b0;
    lap_pulse_d = 1'b0;
    lap_cnt_d   = lap_cnt_q;
    if (en) begin
      case (state_q)
        SYNC: begin
          if (is_onehot_s) begin
            idx_d   = pos_s;
            prev_d  = ring_in;
            valid_d = 1'b1;
            state_d = TRACK;
          end else begin
            oh_err_d = 1'b1;
            valid_d  = 1'b0;
          end
        end
        TRACK: begin
          if (!is_onehot_s) begin
            oh_err_d = 1'b1;
            valid_d  = 1'b0;
            state_d  = SYNC;
          end else if (ring_in == succ_s) begin
            idx_d   = pos_s;
            prev_d  = ring_in;
            valid_d = 1'b1;
            // Wrap from the top position back to 0 completes a lap.
            if (prev_q[N-1]) begin
              lap_pulse_d = 1'b1;
              lap_cnt_d   = lap_cnt_q + {{(LAP_W-1){1'b0}}, 1'b1};
            end else begin
              lap_pulse_d = 1'b0;
            end
          end else begin
            seq_err_d = 1'b1;
            idx_d     = pos_s;
            prev_d    = ring_in;
            valid_d   = 1'b1;
          end
        end
        default: begin
          state_d = SYNC;
          valid_d = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SYNC;
      prev_q      <= {N{1'b0}};
      idx_q       <= {IDX_W{1'b0}};
      valid_q     <= 1'b0;
      oh_err_q    <= 1'b0;
      seq_err_q   <= 1'b0;
      lap_pulse_q <= 1'b0;
      lap_cnt_q   <= {LAP_W{1'b0}};
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      idx_q       <= idx_d;
      valid_q     <= valid_d;
      oh_err_q    <= oh_err_d;
      seq_err_q   <= seq_err_d;
      lap_pulse_q <= lap_pulse_d;
      lap_cnt_q   <= lap_cnt_d;
    end
  end

`ifdef RING_DEC_ERR_COUNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((oh_err_d || seq_err_d) && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

  assign idx        = idx_q;
  assign idx_valid  = valid_q;
  assign onehot_err = oh_err_q;
  assign seq_err    = seq_err_q;
  assign lap_pulse  = lap_pulse_q;
  assign lap_cnt    = lap_cnt_q;

endmodule

// File: tb/tb_ring_counter_decoder.sv
// Directed bench for ring_counter_decoder (N=4) with LAP_W=8 and LAP_W=2 instances on shared stimulus.
module tb_ring_counter_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [3:0] ring_in = 4'b0000;

  logic [1:0] idx, idx2;
  logic       idx_valid, idx_valid2;
  logic       onehot_err, onehot_err2;
  logic       seq_err, seq_err2;
  logic       lap_pulse, lap_pulse2;
  logic [7:0] lap_cnt;
  logic [1:0] lap_cnt2;
`ifdef RING_DEC_ERR_COUNT_EN
  logic [7:0] err_cnt, err_cnt2;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ring_counter_decoder #(.N(4), .LAP_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .ring_in(ring_in),
    .idx(idx), .idx_valid(idx_valid), .onehot_err(onehot_err),
    .seq_err(seq_err), .lap_pulse(lap_pulse),
`ifdef RING_DEC_ERR_COUNT_EN
    .err_cnt(err_cnt),
`endif
    .lap_cnt(lap_cnt)
  );

  ring_counter_decoder #(.N(4), .LAP_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .ring_in(ring_in),
    .idx(idx2), .idx_valid(idx_valid2), .onehot_err(onehot_err2),
    .seq_err(seq_err2), .lap_pulse(lap_pulse2),
`ifdef RING_DEC_ERR_COUNT_EN
    .err_cnt(err_cnt2),
`endif
    .lap_cnt(lap_cnt2)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [3:0] v);
    @(negedge clk);
    rst     = r;
    en      = e;
    ring_in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [1:0] e_idx, input logic e_val,
                         input logic e_oh, input logic e_sq, input logic e_lp,
                         input logic [7:0] e_lap);
    check_eq({tag, ".idx"}, 32'(idx), 32'(e_idx));
    check_eq({tag, ".valid"}, 32'(idx_valid), 32'(e_val));
    check_eq({tag, ".oh_err"}, 32'(onehot_err), 32'(e_oh));
    check_eq({tag, ".seq_err"}, 32'(seq_err), 32'(e_sq));
    check_eq({tag, ".lap_pulse"}, 32'(lap_pulse), 32'(e_lp));
    check_eq({tag, ".lap_cnt"}, 32'(lap_cnt), 32'(e_lap));
  endtask

  initial begin
    logic [3:0] seq4 [4];
    seq4[0] = 4'b0010; seq4[1] = 4'b0100; seq4[2] = 4'b1000; seq4[3] = 4'b0001;

    // Reset for two cycles
    step(1'b1, 1'b1, 4'b0001);
    step(1'b1, 1'b1, 4'b0001);
    chk_all("reset", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

    // Lock and one full lap
    step(1'b0, 1'b1, 4'b0001); chk_all("lap_a0", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b1, 4'b0010); chk_all("lap_a1", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b1, 4'b0100); chk_all("lap_a2", 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b1, 4'b1000); chk_all("lap_a3", 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b1, 4'b0001); chk_all("lap_a4", 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1);

    // Zero vector in TRACK, then relock with no seq_err
    step(1'b0, 1'b1, 4'b0010); chk_all("pre_zero", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    step(1'b0, 1'b1, 4'b0000); chk_all("zero", 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
    step(1'b0, 1'b1, 4'b0100); chk_all("relock", 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);

    // Skip from 0001 to 0100 is a sequence error; 1000 then follows cleanly
    step(1'b0, 1'b1, 4'b1000); chk_all("to3", 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    step(1'b0, 1'b1, 4'b0001); chk_all("to0", 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd2);
    step(1'b0, 1'b1, 4'b0100); chk_all("skip", 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 8'd2);
    step(1'b0, 1'b1, 4'b1000); chk_all("after_skip", 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2);

    // Two bits set
    step(1'b0, 1'b1, 4'b0110); chk_all("two_bits", 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2);
    step(1'b0, 1'b1, 4'b1111); chk_all("all_bits_sync", 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2);
    step(1'b0, 1'b1, 4'b0001); chk_all("lock0", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2);
    // Repeat of the same vector is not its successor
    step(1'b0, 1'b1, 4'b0001); chk_all("repeat", 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd2);

    // en=0 holds state and suppresses pulses
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 4'($urandom_range(0, 15)));
      chk_all("en_low", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2);
    end
    // Successor after the idle gap still tracks from the held reference
    step(1'b0, 1'b1, 4'b0010); chk_all("after_idle", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2);

    // Five clean laps; LAP_W=2 instance wraps 1,2,3,0,1
    step(1'b1, 1'b0, 4'b0000);
    step(1'b0, 1'b1, 4'b0001);
    check_eq("laps.lock_valid", 32'(idx_valid2), 32'd1);
    for (int l = 1; l <= 5; l++) begin
      for (int s = 0; s < 4; s++) begin
        step(1'b0, 1'b1, seq4[s]);
      end
      check_eq("laps.lap_cnt8", 32'(lap_cnt), 32'(l));
      check_eq("laps.lap_cnt2", 32'(lap_cnt2), 32'(l % 4));
      check_eq("laps.pulse2", 32'(lap_pulse2), 32'd1);
    end

    // Reset mid-lap wins over en
    step(1'b0, 1'b1, 4'b0010);
    step(1'b0, 1'b1, 4'b0100);
    step(1'b1, 1'b1, 4'b1000);
    chk_all("mid_rst", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    check_eq("mid_rst.lap_cnt2", 32'(lap_cnt2), 32'd0);
    check_eq("mid_rst.valid2", 32'(idx_valid2), 32'd0);

`ifdef RING_DEC_ERR_COUNT_EN
    check_eq("errcnt.reset", 32'(err_cnt), 32'd0);
    // Each 0000/0001 pair yields exactly one one-hot error
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 1'b1, (i % 2 == 0) ? 4'b0000 : 4'b0001);
    end
    check_eq("errcnt.150", 32'(err_cnt), 32'd150);
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 1'b1, (i % 2 == 0) ? 4'b0000 : 4'b0001);
    end
    check_eq("errcnt.sat", 32'(err_cnt), 32'd255);
    step(1'b0, 1'b1, 4'b0000);
    check_eq("errcnt.hold", 32'(err_cnt), 32'd255);
    step(1'b1, 1'b0, 4'b0000);
    check_eq("errcnt.rst", 32'(err_cnt), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
